// File: rtl/vr_ready_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vr_ready_responder : valid/ready sink with programmable ready delay, output  |
// | FIFO and sticky protocol-error flag. Option: VR_RESP_ERR_CNT_EN -> err_count |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module vr_ready_responder #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int READY_DELAY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       proto_err,
    output logic [15:0]                hs_count
`ifdef VR_RESP_ERR_CNT_EN
    ,
    output logic [7:0]                 err_count
`endif
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [7:0]         c_delay = 8'(READY_DELAY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_in_ready;
    logic                  r_proto_err;
    logic [15:0]           r_hs_count;

    logic [DW-1:0]         r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_space;

    assign w_space = (r_count < c_depth);
    assign w_push  = (r_state == S_ACK) && in_valid;
    assign w_pop   = (r_count != '0) && out_ready;

    // r_in_ready is kept equal to (r_state == S_ACK) by setting it on every ACK entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_in_ready  <= 1'b0;
            r_proto_err <= 1'b0;
            r_hs_count  <= 16'd0;
        end else begin
            r_in_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= c_delay;
                        if ((c_delay == 8'd0) && w_space) begin
                            r_state    <= S_ACK;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!in_valid) begin
                        r_proto_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_cnt > 8'd1) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (w_space) begin
                        r_state    <= S_ACK;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_cnt <= 8'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    if (in_valid) begin
                        r_hs_count <= r_hs_count + 16'd1;
                    end else begin
                        r_proto_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef VR_RESP_ERR_CNT_EN
    logic       w_err_event;
    logic [7:0] r_err_count;

    assign w_err_event = ((r_state == S_WAIT) || (r_state == S_ACK)) && !in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (w_err_event && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign proto_err  = r_proto_err;
    assign hs_count   = r_hs_count;

endmodule
`default_nettype wire

// File: tb/tb_vr_ready_responder.sv
`default_nettype none
// Directed bench for vr_ready_responder: one DUT with READY_DELAY=3, one with READY_DELAY=0.
module tb_vr_ready_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, proto_err;
    logic [7:0]  in_data, out_data;
    logic [2:0]  fifo_count;
    logic [15:0] hs_count;
    logic        valid0, ready0, ovalid0, oready0, perr0;
    logic [7:0]  data0, odata0;
    logic [2:0]  cnt0;
    logic [15:0] hs0;
`ifdef VR_RESP_ERR_CNT_EN
    logic [7:0]  err_count, err_count0;
`endif

    int vectors = 0;
    int errors  = 0;
    int exp_hs  = 0;

    always #5 clk = ~clk;

    vr_ready_responder #(.DW(8), .DEPTH(4), .READY_DELAY(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fifo_count(fifo_count), .proto_err(proto_err), .hs_count(hs_count)
`ifdef VR_RESP_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    vr_ready_responder #(.DW(8), .DEPTH(4), .READY_DELAY(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(valid0), .in_data(data0), .in_ready(ready0),
        .out_valid(ovalid0), .out_data(odata0), .out_ready(oready0),
        .fifo_count(cnt0), .proto_err(perr0), .hs_count(hs0)
`ifdef VR_RESP_ERR_CNT_EN
        , .err_count(err_count0)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        valid0 = 1'b0; data0 = 8'h00; oready0 = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        vectors++; if (hs_count !== 16'd0) begin errors++; $display("FAIL reset_hs_count: got %0d want 0", hs_count); end
        vectors++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", ready0); end
`ifdef VR_RESP_ERR_CNT_EN
        vectors++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        vectors++; if (err_count0 !== 8'd0) begin errors++; $display("FAIL reset_err_count0: got %0d want 0", err_count0); end
`endif
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5;
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (in_ready !== (i == 4)) begin
                errors++; $display("FAIL single_ready step %0d: got %b want %b", i, in_ready, (i == 4));
            end
        end
        step();
        in_valid = 1'b0; exp_hs++;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_out_data: got %h want a5", out_data); end
        vectors++; if (hs_count !== 16'(exp_hs)) begin errors++; $display("FAIL single_hs_count: got %0d want %0d", hs_count, exp_hs); end
        vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto_err: got %b want 0", proto_err); end
        vectors++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_fifo_count: got %0d want 1", fifo_count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_pop: got %0d want 0", fifo_count); end
    endtask

    task automatic test_backpressure();
        int   accepts;
        logic e, prev_e;
        accepts = 0; prev_e = 1'b0;
        out_ready = 1'b0; in_data = 8'h10; in_valid = 1'b1;
        // Continuous requests: IDLE + 3 WAIT + ACK gives an ACK every 5 cycles until full.
        for (int i = 1; i <= 30; i++) begin
            step();
            if (prev_e) begin
                accepts++; exp_hs++; in_data = 8'h10 + 8'(accepts);
            end
            e = (i >= 4) && (i <= 19) && (((i - 4) % 5) == 0);
            vectors++;
            if (in_ready !== e) begin
                errors++; $display("FAIL bp_ready step %0d: got %b want %b", i, in_ready, e);
            end
            prev_e = e;
        end
        vectors++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full_count: got %0d want 4", fifo_count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_pop_cycle: got %b want 0", in_ready); end
        vectors++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL bp_count_after_pop: got %0d want 3", fifo_count); end
        vectors++; if (out_data !== 8'h11) begin errors++; $display("FAIL bp_head_after_pop: got %h want 11", out_data); end
        step();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_resume: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; exp_hs++;
        vectors++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_refill_count: got %0d want 4", fifo_count); end
        vectors++; if (hs_count !== 16'(exp_hs)) begin errors++; $display("FAIL bp_hs_count: got %0d want %0d", hs_count, exp_hs); end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (out_data !== 8'(8'h11 + j)) begin
                errors++; $display("FAIL bp_drain_order %0d: got %h want %h", j, out_data, 8'(8'h11 + j));
            end
            step();
        end
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_early_drop();
        in_valid = 1'b1; in_data = 8'hEE;
        step();
        vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL drop_err_early: got %b want 0", proto_err); end
        step();
        in_valid = 1'b0;
        step();
        vectors++; if (proto_err !== 1'b1) begin errors++; $display("FAIL drop_err_set: got %b want 1", proto_err); end
        vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL drop_no_push: got %0d want 0", fifo_count); end
        vectors++; if (hs_count !== 16'(exp_hs)) begin errors++; $display("FAIL drop_hs_count: got %0d want %0d", hs_count, exp_hs); end
        step();
        in_valid = 1'b1; in_data = 8'h3C;
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (in_ready !== (i == 4)) begin
                errors++; $display("FAIL drop_retry_ready step %0d: got %b want %b", i, in_ready, (i == 4));
            end
        end
        step();
        in_valid = 1'b0; exp_hs++;
        vectors++; if (out_data !== 8'h3C) begin errors++; $display("FAIL drop_retry_data: got %h want 3c", out_data); end
        vectors++; if (hs_count !== 16'(exp_hs)) begin errors++; $display("FAIL drop_retry_hs: got %0d want %0d", hs_count, exp_hs); end
        vectors++; if (proto_err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky: got %b want 1", proto_err); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        oready0 = 1'b0; valid0 = 1'b1; data0 = 8'hB0;
        // READY_DELAY=0: IDLE and ACK alternate, so ready is high after every odd step.
        for (int i = 1; i <= 6; i++) begin
            step();
            if ((i % 2) == 0) begin
                accepts++; data0 = 8'hB0 + 8'(accepts);
            end
            vectors++;
            if (ready0 !== ((i % 2) == 1)) begin
                errors++; $display("FAIL b2b_ready step %0d: got %b want %b", i, ready0, ((i % 2) == 1));
            end
        end
        valid0 = 1'b0;
        vectors++; if (cnt0 !== 3'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", cnt0); end
        vectors++; if (hs0 !== 16'd3) begin errors++; $display("FAIL b2b_hs_count: got %0d want 3", hs0); end
        oready0 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            vectors++;
            if (odata0 !== 8'(8'hB0 + j)) begin
                errors++; $display("FAIL b2b_order %0d: got %h want %h", j, odata0, 8'(8'hB0 + j));
            end
            step();
        end
        oready0 = 1'b0;
        vectors++; if (ovalid0 !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", ovalid0); end
        vectors++; if (perr0 !== 1'b0) begin errors++; $display("FAIL b2b_proto_err: got %b want 0", perr0); end
    endtask

`ifdef VR_RESP_ERR_CNT_EN
    task automatic test_err_count();
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            in_valid = 1'b1; step();
            in_valid = 1'b0; step();
            if (k == 10) begin
                vectors++; if (err_count !== 8'd10) begin errors++; $display("FAIL err_cnt_10: got %0d want 10", err_count); end
            end
            if (k == 254) begin
                vectors++; if (err_count !== 8'hFE) begin errors++; $display("FAIL err_cnt_254: got %0d want 254", err_count); end
            end
            if (k == 256) begin
                vectors++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_cnt_256: got %0d want 255", err_count); end
            end
        end
        vectors++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_cnt_sat: got %0d want 255", err_count); end
        vectors++; if (proto_err !== 1'b1) begin errors++; $display("FAIL err_cnt_proto: got %b want 1", proto_err); end
    endtask
`endif

    task automatic test_reset_in_ack();
        in_valid = 1'b1; in_data = 8'h77;
        for (int i = 1; i <= 4; i++) step();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rack_in_ack: got %b want 1", in_ready); end
        rst = 1'b1;
        step();
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rack_ready: got %b want 0", in_ready); end
        vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rack_count: got %0d want 0", fifo_count); end
        vectors++; if (hs_count !== 16'd0) begin errors++; $display("FAIL rack_hs: got %0d want 0", hs_count); end
        vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rack_proto_err: got %b want 0", proto_err); end
        rst = 1'b0; in_valid = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rack_no_push: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_early_drop();
        test_back_to_back();
`ifdef VR_RESP_ERR_CNT_EN
        test_err_count();
`endif
        test_reset_in_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
